// File: rtl/pet_video_pkg.sv
// pet_video_pkg: shared types and constants for the character-mode pixel pipe.
//   fetch_state_t  : per-slot VRAM/char-ROM fetch sequencer states
//   PHASE_W        : width of the 16-step intra-slot phase counter
//   BLANK_PATTERN  : glyph row used when nothing valid was fetched
//   REVERSE_BIT    : screen-code bit that selects reverse video
package pet_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VRAM_REQ,
    VRAM_WAIT,
    ROM_REQ,
    ROM_WAIT,
    DONE
  } fetch_state_t;

  localparam int         PHASE_W       = 4;
  localparam logic [7:0] BLANK_PATTERN = 8'h00;
  localparam int         REVERSE_BIT   = 7;

  // Reverse video inverts the whole glyph row when the code's top bit is set.
  function automatic logic [7:0] apply_reverse(input logic [7:0] row, input logic [7:0] code);
    return row ^ {8{code[REVERSE_BIT]}};
  endfunction

endpackage

// File: rtl/pixel_shifter.sv
// pixel_shifter: parallel-in / serial-out glyph row shifter.
//   i_clk, i_rst : clock, async active-high reset
//   i_load       : load i_data (has priority over shift)
//   i_shift      : shift left one place, zero fill
//   i_data       : glyph row, MSB = leftmost pixel
//   o_msb        : current pixel
module pixel_shifter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_sr <= '0;
    else if (i_load)  r_sr <= i_data;
    else if (i_shift) r_sr <= {r_sr[W-2:0], 1'b0};
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/video_pixel_pipe.sv
// video_pixel_pipe: per character slot, latches crtc ma/ra/de, fetches the screen
// code from VRAM and the glyph row from char ROM, then serialises that row during
// the following slot. Syncs are delayed one slot to stay aligned with the pixels.
//   clk16_i/reset_i        : 16 MHz clock, async active-high reset
//   cclk_en_i              : slot boundary strobe (every 16 clocks)
//   de_i/ma_i/ra_i/gfx_i   : crtc display enable, refresh/raster address, charset
//   h_sync_i/v_sync_i      : crtc syncs -> h_sync_o/v_sync_o (one slot later)
//   vram_req_o/addr/valid/data : VRAM read handshake (req held until valid)
//   rom_req_o/addr/valid/data  : char ROM read handshake (req held until valid)
//   video_o                : pixel, 2 clocks per pixel
//   underrun_o             : 1-cycle pulse when a fetch misses its slot deadline
module video_pixel_pipe
  import pet_video_pkg::*;
#(
  parameter int VRAM_AW       = 11,
  parameter int ROM_AW        = 11,
  parameter int TIMEOUT_PHASE = 14
) (
  input  logic               clk16_i,
  input  logic               reset_i,
  input  logic               cclk_en_i,
  input  logic               de_i,
  input  logic [13:0]        ma_i,
  input  logic [4:0]         ra_i,
  input  logic               h_sync_i,
  input  logic               v_sync_i,
  input  logic               gfx_i,
  output logic               vram_req_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  input  logic               vram_valid_i,
  input  logic [7:0]         vram_data_i,
  output logic               rom_req_o,
  output logic [ROM_AW-1:0]  rom_addr_o,
  input  logic               rom_valid_i,
  input  logic [7:0]         rom_data_i,
  output logic               video_o,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               underrun_o
);

  logic [PHASE_W-1:0] r_phase;
  fetch_state_t       r_state, w_state_nxt;
  logic [VRAM_AW-1:0] r_ma;
  logic [4:0]         r_ra;
  logic               r_gfx, r_hs, r_vs, r_hs_d, r_vs_d;
  logic [7:0]         r_code, r_pattern, w_pattern_nxt, w_load_data;
  logic               r_underrun, w_underrun_nxt, w_code_we;
  logic               w_active;
  logic               w_unused_ma;

  assign w_unused_ma = ^ma_i[13:VRAM_AW];

  // Phase realigns to the strobe so pixel timing never drifts from the crtc.
  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i)        r_phase <= '0;
    else if (cclk_en_i) r_phase <= '0;
    else                r_phase <= r_phase + 1'b1;
  end

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      r_ma   <= '0;
      r_ra   <= '0;
      r_gfx  <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else if (cclk_en_i) begin
      r_ma   <= ma_i[VRAM_AW-1:0];
      r_ra   <= ra_i;
      r_gfx  <= gfx_i;
      r_hs   <= h_sync_i;
      r_vs   <= v_sync_i;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  assign w_active = (r_state != IDLE) && (r_state != DONE);

  always_comb begin
    w_state_nxt    = r_state;
    w_pattern_nxt  = r_pattern;
    w_code_we      = 1'b0;
    w_underrun_nxt = 1'b0;
    // A slot that never reached DONE has nothing trustworthy to show.
    w_load_data    = (r_state == DONE) ? r_pattern : BLANK_PATTERN;
    if (cclk_en_i) begin
      w_underrun_nxt = w_active;
      if (de_i) begin
        w_state_nxt = VRAM_REQ;
      end else begin
        w_state_nxt   = DONE;
        w_pattern_nxt = BLANK_PATTERN;
      end
    end else begin
      unique case (r_state)
        VRAM_REQ:  w_state_nxt = VRAM_WAIT;
        VRAM_WAIT: begin
          if (vram_valid_i) begin
            w_code_we = 1'b1;
            // Raster rows 8+ are the inter-line gap: no glyph data, only reverse fill.
            if (r_ra[4:3] == 2'b00) begin
              w_state_nxt = ROM_REQ;
            end else begin
              w_state_nxt   = DONE;
              w_pattern_nxt = apply_reverse(BLANK_PATTERN, vram_data_i);
            end
          end
        end
        ROM_REQ:   w_state_nxt = ROM_WAIT;
        ROM_WAIT: begin
          if (rom_valid_i) begin
            w_state_nxt   = DONE;
            w_pattern_nxt = apply_reverse(rom_data_i, r_code);
          end
        end
        default:   w_state_nxt = r_state;
      endcase
      // Deadline: a fetch still unresolved after this phase is abandoned blank.
      if (w_active && (w_state_nxt != DONE) && (r_phase == PHASE_W'(TIMEOUT_PHASE))) begin
        w_state_nxt    = DONE;
        w_pattern_nxt  = BLANK_PATTERN;
        w_underrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      r_code     <= '0;
      r_pattern  <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_code_we) r_code <= vram_data_i;
      r_pattern  <= w_pattern_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Shift on odd phases: pixel n spans phases 2n and 2n+1.
  pixel_shifter #(.W(8)) u_shifter (
    .i_clk   (clk16_i),
    .i_rst   (reset_i),
    .i_load  (cclk_en_i),
    .i_shift (r_phase[0]),
    .i_data  (w_load_data),
    .o_msb   (video_o)
  );

  assign vram_req_o  = (r_state == VRAM_REQ) || (r_state == VRAM_WAIT);
  assign rom_req_o   = (r_state == ROM_REQ)  || (r_state == ROM_WAIT);
  assign vram_addr_o = r_ma;
  assign rom_addr_o  = ROM_AW'({r_gfx, r_code[6:0], r_ra[2:0]});
  assign h_sync_o    = r_hs_d;
  assign v_sync_o    = r_vs_d;
  assign underrun_o  = r_underrun;

endmodule
